// File: rtl/gowin_pll_lock_manager_if.sv
// Purpose: bundles the PLL-side and control-side signals of the lock manager.
// Ports  : lock_i/restart_i/retry_i towards the manager; pll_reset_o, icpsel_o,
//          lpfres_o, lpfcap_o, locked_o, fail_o, cfg_idx_o, lock_loss_o from it.
interface gowin_pll_lock_manager_if #(
  parameter int IDX_W      = 2,
  parameter int LOSS_CNT_W = 8
);
  logic                  lock_i;
  logic                  restart_i;
  logic                  retry_i;
  logic                  pll_reset_o;
  logic [5:0]            icpsel_o;
  logic [2:0]            lpfres_o;
  logic [1:0]            lpfcap_o;
  logic                  locked_o;
  logic                  fail_o;
  logic [IDX_W-1:0]      cfg_idx_o;
  logic [LOSS_CNT_W-1:0] lock_loss_o;

  // Side that drives the PLL lock and the control pulses.
  modport master (
    output lock_i, restart_i, retry_i,
    input  pll_reset_o, icpsel_o, lpfres_o, lpfcap_o,
    input  locked_o, fail_o, cfg_idx_o, lock_loss_o
  );

  // The lock manager itself.
  modport slave (
    input  lock_i, restart_i, retry_i,
    output pll_reset_o, icpsel_o, lpfres_o, lpfcap_o,
    output locked_o, fail_o, cfg_idx_o, lock_loss_o
  );
endinterface

// File: rtl/gowin_pll_lock_manager.sv
// Purpose: sequences PLL reset, waits for lock, sweeps loop-filter settings on
//          timeout, qualifies lock stability and recovers from lock loss.
// Latency: locked_o rises LOCK_STABLE+3 cycles after lock_i rises (2-flop sync,
//          LOCK_STABLE qualify cycles, registered output); no backpressure.
// Ports  : clkin/reset plain; pll_if.slave carries lock/restart/retry inputs and
//          pll_reset, icpsel/lpfres/lpfcap, locked, fail, cfg_idx, lock_loss outputs.
module gowin_pll_lock_manager #(
  parameter int                     NUM_CFGS     = 4,
  parameter logic [NUM_CFGS*11-1:0] CFG_TABLE    = {NUM_CFGS{11'b000000_000_00}},
  parameter int                     RESET_CYCLES = 16,
  parameter int                     LOCK_TIMEOUT = 4096,
  parameter int                     LOCK_STABLE  = 256,
  parameter int                     MAX_SWEEPS   = 2,
  parameter int                     LOSS_CNT_W   = 8
) (
  input  logic                    clkin,
  input  logic                    reset,
  gowin_pll_lock_manager_if.slave pll_if
);

  localparam int IDX_W = (NUM_CFGS > 1) ? $clog2(NUM_CFGS) : 1;
  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int SWP_W = (MAX_SWEEPS > 0) ? $clog2(MAX_SWEEPS + 1) : 1;

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_QUALIFY   = 3'd2;
  localparam logic [2:0] S_LOCKED    = 3'd3;
  localparam logic [2:0] S_FAILED    = 3'd4;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CFGS - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic [2:0]            r_state;
  logic [RST_W-1:0]      r_rst_cnt;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic [STB_W-1:0]      r_stab_cnt;
  logic [SWP_W-1:0]      r_sweep_cnt;
  logic [IDX_W-1:0]      r_cfg_idx;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic [10:0]           r_cfg;
  logic                  r_pll_reset;
  logic                  r_locked;
  logic                  r_fail;

  logic                  w_lock_s;
  logic                  w_restart;
  logic [2:0]            w_nxt_state;
  logic [IDX_W-1:0]      w_nxt_cfg_idx;
  logic [SWP_W-1:0]      w_nxt_sweep;
  logic [SWP_W-1:0]      w_sweep_inc;
  logic                  w_loss_inc;
  logic                  w_enter_rst;
  logic [10:0]           w_cfg_entry;

  assign w_lock_s    = r_sync2;
  // restart_i has no effect in FAILED; only retry_i leaves that state.
  assign w_restart   = pll_if.restart_i && (r_state != S_FAILED);
  assign w_sweep_inc = r_sweep_cnt + SWP_W'(1);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cfg_idx = r_cfg_idx;
    w_nxt_sweep   = r_sweep_cnt;
    w_loss_inc    = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_rst_cnt == RST_LAST) w_nxt_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_nxt_state = S_QUALIFY;
        end else if (r_tmo_cnt == TMO_LAST) begin
          if (r_cfg_idx != IDX_LAST) begin
            w_nxt_cfg_idx = r_cfg_idx + IDX_W'(1);
            w_nxt_state   = S_RESET_PLL;
          end else begin
            // End of a full pass over the table.
            w_nxt_cfg_idx = '0;
            w_nxt_sweep   = w_sweep_inc;
            if ((MAX_SWEEPS != 0) && (w_sweep_inc == SWP_W'(MAX_SWEEPS)))
              w_nxt_state = S_FAILED;
            else
              w_nxt_state = S_RESET_PLL;
          end
        end
      end
      S_QUALIFY: begin
        // Dropping back keeps tmo_cnt, so a chattering lock still times out.
        if (!w_lock_s) begin
          w_nxt_state = S_WAIT_LOCK;
        end else if (r_stab_cnt == STB_LAST) begin
          w_nxt_state = S_LOCKED;
          w_nxt_sweep = '0;
        end
      end
      S_LOCKED: begin
        if (!w_lock_s) begin
          w_nxt_state = S_RESET_PLL;
          w_loss_inc  = 1'b1;
        end
      end
      S_FAILED: begin
        if (pll_if.retry_i) begin
          w_nxt_cfg_idx = '0;
          w_nxt_sweep   = '0;
          w_nxt_state   = S_RESET_PLL;
        end
      end
      default: w_nxt_state = S_RESET_PLL;
    endcase
    // A user restart beats any timeout or lock-loss decision made above.
    if (w_restart) begin
      w_nxt_state   = S_RESET_PLL;
      w_nxt_cfg_idx = r_cfg_idx;
      w_nxt_sweep   = '0;
      w_loss_inc    = 1'b0;
    end
  end

  // Restart inside RESET_PLL counts as a fresh entry so the full reset is re-run.
  assign w_enter_rst = (w_nxt_state == S_RESET_PLL) &&
                       ((r_state != S_RESET_PLL) || w_restart);
  assign w_cfg_entry = CFG_TABLE[w_nxt_cfg_idx*11 +: 11];

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= S_RESET_PLL;
      r_rst_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_stab_cnt  <= '0;
      r_sweep_cnt <= '0;
      r_cfg_idx   <= '0;
      r_loss_cnt  <= '0;
      r_cfg       <= CFG_TABLE[10:0];
      r_pll_reset <= 1'b1;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_sync1     <= pll_if.lock_i;
      r_sync2     <= r_sync1;
      r_state     <= w_nxt_state;
      r_cfg_idx   <= w_nxt_cfg_idx;
      r_sweep_cnt <= w_nxt_sweep;

      if (w_enter_rst)
        r_rst_cnt <= '0;
      else if (r_state == S_RESET_PLL)
        r_rst_cnt <= r_rst_cnt + RST_W'(1);

      if (w_enter_rst)
        r_tmo_cnt <= '0;
      else if ((r_state == S_WAIT_LOCK) && !w_lock_s)
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (r_state != S_QUALIFY)
        r_stab_cnt <= '0;
      else if (w_lock_s)
        r_stab_cnt <= r_stab_cnt + STB_W'(1);

      if (w_loss_inc && (r_loss_cnt != {LOSS_CNT_W{1'b1}}))
        r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);

      // Loop-filter settings only change while the PLL is being held in reset.
      if (w_enter_rst)
        r_cfg <= w_cfg_entry;

      // Outputs are decoded from the next state so they line up with r_state.
      r_pll_reset <= (w_nxt_state == S_RESET_PLL) || (w_nxt_state == S_FAILED);
      r_locked    <= (w_nxt_state == S_LOCKED);
      r_fail      <= (w_nxt_state == S_FAILED);
    end
  end

  assign pll_if.pll_reset_o = r_pll_reset;
  assign pll_if.icpsel_o    = r_cfg[10:5];
  assign pll_if.lpfres_o    = r_cfg[4:2];
  assign pll_if.lpfcap_o    = r_cfg[1:0];
  assign pll_if.locked_o    = r_locked;
  assign pll_if.fail_o      = r_fail;
  assign pll_if.cfg_idx_o   = r_cfg_idx;
  assign pll_if.lock_loss_o = r_loss_cnt;

endmodule

// File: tb/tb_gowin_pll_lock_manager.sv
// Purpose: directed bench for gowin_pll_lock_manager with a small 4-entry table.
// Timing : inputs are driven and outputs sampled 1 time unit after each rising
//          edge; "cycle c" below is the interval that starts at that edge.
module tb_gowin_pll_lock_manager;

  localparam logic [10:0] E0 = {6'd3,  3'd1, 2'd0};
  localparam logic [10:0] E1 = {6'd12, 3'd2, 2'd1};
  localparam logic [10:0] E2 = {6'd33, 3'd5, 2'd2};
  localparam logic [10:0] E3 = {6'd63, 3'd7, 2'd3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gowin_pll_lock_manager_if #(.IDX_W(2), .LOSS_CNT_W(2)) bus ();

  gowin_pll_lock_manager #(
    .NUM_CFGS    (4),
    .CFG_TABLE   ({E3, E2, E1, E0}),
    .RESET_CYCLES(4),
    .LOCK_TIMEOUT(16),
    .LOCK_STABLE (8),
    .MAX_SWEEPS  (2),
    .LOSS_CNT_W  (2)
  ) dut (
    .clkin (clk),
    .reset (rst),
    .pll_if(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int w;
  logic [10:0] ent [4];

  typedef struct {
    logic       lock;
    logic       restart;
    logic       retry;
    int         n;
    logic       pll;
    logic       locked;
    logic       fail;
    logic [1:0] cfg;
    logic [1:0] loss;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t v(input logic lock, restart, retry, input int n,
                             input logic pll, locked, fail, input logic [1:0] cfg, loss);
    vec_t r;
    r.lock = lock; r.restart = restart; r.retry = retry; r.n = n;
    r.pll = pll; r.locked = locked; r.fail = fail; r.cfg = cfg; r.loss = loss;
    return r;
  endfunction

  function automatic logic [6:0] mk(input logic pll, locked, fail,
                                    input logic [1:0] cfg, loss);
    return {pll, locked, fail, cfg, loss};
  endfunction

  function automatic logic [6:0] st();
    return {bus.pll_reset_o, bus.locked_o, bus.fail_o, bus.cfg_idx_o, bus.lock_loss_o};
  endfunction

  function automatic logic [10:0] cfgv();
    return {bus.icpsel_o, bus.lpfres_o, bus.lpfcap_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    ent[0] = E0; ent[1] = E1; ent[2] = E2; ent[3] = E3;
    bus.lock_i = 1'b0; bus.restart_i = 1'b0; bus.retry_i = 1'b0;

    // Lock after 5 cycles, one lock-loss, relock, restart from LOCKED, retry ignored.
    //                lk rs rt  n  pll lkd fail cfg loss      cycle reached
    vt.push_back(v(0, 0, 0, 3,  1,  0,  0,  0,  0));      // 3  still in reset
    vt.push_back(v(0, 0, 0, 1,  0,  0,  0,  0,  0));      // 4  reset released
    vt.push_back(v(0, 0, 0, 5,  0,  0,  0,  0,  0));      // 9  lock_i rises here
    vt.push_back(v(1, 0, 0, 10, 0,  0,  0,  0,  0));      // 19 one short of lock
    vt.push_back(v(1, 0, 0, 1,  0,  1,  0,  0,  0));      // 20 = 9 + 11
    vt.push_back(v(0, 0, 0, 1,  0,  1,  0,  0,  0));      // 21 lock_i low in 20
    vt.push_back(v(1, 0, 0, 1,  0,  1,  0,  0,  0));      // 22
    vt.push_back(v(1, 0, 0, 1,  1,  0,  0,  0,  1));      // 23 = drop + 3
    vt.push_back(v(1, 0, 0, 3,  1,  0,  0,  0,  1));      // 26
    vt.push_back(v(1, 0, 0, 1,  0,  0,  0,  0,  1));      // 27 WAIT, lock_s high
    vt.push_back(v(1, 0, 0, 8,  0,  0,  0,  0,  1));      // 35
    vt.push_back(v(1, 0, 0, 1,  0,  1,  0,  0,  1));      // 36 relocked
    vt.push_back(v(1, 1, 0, 1,  1,  0,  0,  0,  1));      // 37 restart, no loss
    vt.push_back(v(1, 0, 0, 3,  1,  0,  0,  0,  1));      // 40
    vt.push_back(v(1, 0, 0, 1,  0,  0,  0,  0,  1));      // 41
    vt.push_back(v(1, 0, 0, 8,  0,  0,  0,  0,  1));      // 49
    vt.push_back(v(1, 0, 0, 1,  0,  1,  0,  0,  1));      // 50
    vt.push_back(v(1, 0, 1, 1,  0,  1,  0,  0,  1));      // 51 retry ignored
    vt.push_back(v(1, 0, 0, 1,  0,  1,  0,  0,  1));      // 52

    // Reset values while reset is held.
    rst = 1'b1;
    tick(2);
    chk("rst_state", 32'({st(), cfgv()}), 32'({mk(1, 0, 0, 0, 0), E0}));
    rst = 1'b0;                                            // cycle 0

    foreach (vt[i]) begin
      bus.lock_i    = vt[i].lock;
      bus.restart_i = vt[i].restart;
      bus.retry_i   = vt[i].retry;
      tick(vt[i].n);
      chk($sformatf("vec%0d", i), 32'(st()),
          32'(mk(vt[i].pll, vt[i].locked, vt[i].fail, vt[i].cfg, vt[i].loss)));
    end
    bus.restart_i = 1'b0; bus.retry_i = 1'b0;

    // Four more lock-loss events; the 2-bit counter saturates at 3.
    for (int k = 2; k <= 5; k++) begin
      bus.lock_i = 1'b0; tick(1);
      bus.lock_i = 1'b1; tick(2);
      chk($sformatf("loss_evt%0d", k), 32'(st()), 32'(mk(1, 0, 0, 0, (k > 3) ? 2'd3 : 2'(k))));
      w = 0;
      while (!bus.locked_o && w < 40) begin tick(1); w++; end
      chk($sformatf("relock%0d", k), 32'(bus.locked_o), 32'd1);
    end

    // Sweep with lock_i tied low: 8 steps of 20 cycles, then FAILED.
    bus.lock_i = 1'b0;
    rst = 1'b1; tick(1); rst = 1'b0;                       // cycle 0
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 20; j++) begin
        chk($sformatf("sweep%0d_%0d", k, j), 32'({st(), cfgv()}),
            32'({mk(j < 4, 0, 0, 2'(k % 4), 0), ent[k % 4]}));
        tick(1);
      end
    end
    chk("failed", 32'(st()), 32'(mk(1, 0, 1, 0, 0)));     // 160
    bus.restart_i = 1'b1; tick(1); bus.restart_i = 1'b0;
    chk("failed_restart_ign", 32'(st()), 32'(mk(1, 0, 1, 0, 0)));
    bus.retry_i = 1'b1; tick(1); bus.retry_i = 1'b0;       // 162 RESET_PLL
    chk("retry_exit", 32'(st()), 32'(mk(1, 0, 0, 0, 0)));
    tick(3);
    chk("retry_rst_hold", 32'(st()), 32'(mk(1, 0, 0, 0, 0)));
    tick(1);
    chk("retry_rst_rel", 32'({st(), cfgv()}), 32'({mk(0, 0, 0, 0, 0), E0}));
    tick(155);                                             // 321 last WAIT of cfg 3
    chk("sweep2_last", 32'(st()), 32'(mk(0, 0, 0, 3, 0)));
    tick(1);
    chk("failed2", 32'(st()), 32'(mk(1, 0, 1, 0, 0)));
    bus.restart_i = 1'b1; bus.retry_i = 1'b1; tick(1);
    bus.restart_i = 1'b0; bus.retry_i = 1'b0;
    chk("both_retry_wins", 32'(st()), 32'(mk(1, 0, 0, 0, 0)));

    // Lock at entry 1, then restart from LOCKED.
    tick(20);
    chk("cfg1_reset", 32'({st(), cfgv()}), 32'({mk(1, 0, 0, 1, 0), E1}));
    bus.lock_i = 1'b1;
    tick(12);
    chk("cfg1_not_yet", 32'(st()), 32'(mk(0, 0, 0, 1, 0)));
    tick(1);
    chk("cfg1_locked", 32'(st()), 32'(mk(0, 1, 0, 1, 0)));
    bus.restart_i = 1'b1; bus.lock_i = 1'b0; tick(1); bus.restart_i = 1'b0;
    chk("restart_cfg1", 32'(st()), 32'(mk(1, 0, 0, 1, 0)));
    tick(3);
    chk("restart_hold", 32'(st()), 32'(mk(1, 0, 0, 1, 0)));
    tick(1);
    chk("restart_rel", 32'({st(), cfgv()}), 32'({mk(0, 0, 0, 1, 0), E1}));

    // Asynchronous reset in WAIT_LOCK at entry 2.
    w = 0;
    while (!(bus.cfg_idx_o == 2'd2 && !bus.pll_reset_o) && w < 100) begin tick(1); w++; end
    tick(2);
    chk("pre_async", 32'({st(), cfgv()}), 32'({mk(0, 0, 0, 2, 0), E2}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({st(), cfgv()}), 32'({mk(1, 0, 0, 0, 0), E0}));
    @(posedge clk); #1; rst = 1'b0;                        // cycle 0
    tick(3);
    chk("post_rst_hold", 32'(st()), 32'(mk(1, 0, 0, 0, 0)));
    tick(1);
    chk("post_rst_rel", 32'({st(), cfgv()}), 32'({mk(0, 0, 0, 0, 0), E0}));

    // Lock high 5, low 1, then steady: qualify restarts, lock at c=17 not 11.
    for (int c = 0; c < 17; c++) begin
      chk($sformatf("glitch_q%0d", c), 32'(bus.locked_o), 32'd0);
      bus.lock_i = (c == 5) ? 1'b0 : 1'b1;
      tick(1);
    end
    chk("glitch_lock", 32'(st()), 32'(mk(0, 1, 0, 0, 0)));

    // Chattering lock (1 high, 2 low): no lock, timeout after 16 low WAIT cycles.
    bus.lock_i = 1'b0; bus.restart_i = 1'b1; tick(1); bus.restart_i = 1'b0;
    chk("restart_locked", 32'(st()), 32'(mk(1, 0, 0, 0, 0)));
    tick(4);
    for (int d = 0; d < 45; d++) begin
      chk($sformatf("chatter%0d", d), 32'(st()),
          32'((d < 44) ? mk(0, 0, 0, 0, 0) : mk(1, 0, 0, 1, 0)));
      bus.lock_i = (d % 3 == 0);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
